// File: rtl/memory_pkg.sv
// Shared types and helpers for the memory datapath blocks.
package memory_pkg;

    typedef enum logic [1:0] {
        EMPTY,
        FETCH,
        HOLD
    } rd_state_t;

    // Stored word is {tlast, tstrb, tdata}.
    function automatic int ram_word_width(input int data_width);
        return data_width + data_width / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_fb_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
module axis_fb_ram #(
    parameter int ADDR_WIDTH = 10,
    parameter int WORD_WIDTH = 37
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WORD_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WORD_WIDTH-1:0] rd_data
);

    logic [WORD_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // NOTE: the array and read register carry no reset so they map onto block RAM;
    // the control logic never consumes a word it has not written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axis_frame_buffer.sv
// AXI4-Stream frame buffer with store-and-forward or cut-through release,
// exporting occupancy and complete-frame count.
module axis_frame_buffer
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int STORE_FWD  = 1
) (
    input  logic                    axis_aclk,
    input  logic                    axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tlast,
    input  logic                    s01_axis_tvalid,
    output logic                    s01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tlast,
    output logic                    m01_axis_tvalid,
    input  logic                    m01_axis_tready,
    output logic [ADDR_WIDTH:0]     fill_level,
    output logic [ADDR_WIDTH:0]     frame_count
);

    localparam int                  DEPTH   = 2**ADDR_WIDTH;
    localparam int                  WORD_W  = ram_word_width(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [WORD_W-1:0]     rd_word;
    rd_state_t             state;
    logic                  ready_en;
    logic                  cut_thru;
    logic                  full;
    logic                  wr_en;
    logic                  rd_en;
    logic                  eligible;
    logic                  wr_last;
    logic                  fetched_last;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        full            = (fill_level == DEPTH_L);
        s01_axis_tready = ready_en && !full;
        wr_en           = s01_axis_tvalid && s01_axis_tready;
        wr_last         = wr_en && s01_axis_tlast;
        fetched_last    = (state == FETCH) && rd_word[WORD_W-1];
        eligible        = (fill_level != '0);
        // An oversize frame that filled the RAM keeps streaming until its tlast leaves.
        if (STORE_FWD != 0) begin
            eligible = (frame_count != '0) || full || (cut_thru && fill_level != '0);
        end
        rd_en = eligible && ((state == EMPTY) || (state == HOLD && m01_axis_tready));
    end

    axis_fb_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WORD_WIDTH (WORD_W)
    ) u_ram (
        .clk     (axis_aclk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({s01_axis_tlast, s01_axis_tstrb, s01_axis_tdata}),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            ready_en    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill_level  <= '0;
            frame_count <= '0;
            cut_thru    <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   fill_level <= fill_level + CNT_ONE;
                2'b01:   fill_level <= fill_level - CNT_ONE;
                default: fill_level <= fill_level;
            endcase
            case ({wr_last, fetched_last})
                2'b10:   frame_count <= frame_count + CNT_ONE;
                2'b01:   frame_count <= frame_count - CNT_ONE;
                default: frame_count <= frame_count;
            endcase
            if (STORE_FWD != 0 && rd_en && frame_count == '0) begin
                cut_thru <= 1'b1;
            end else if (fetched_last) begin
                cut_thru <= 1'b0;
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state           <= EMPTY;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
            m01_axis_tlast  <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (rd_en) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    {m01_axis_tlast, m01_axis_tstrb, m01_axis_tdata} <= rd_word;
                    m01_axis_tvalid <= 1'b1;
                    state           <= HOLD;
                end
                HOLD: begin
                    if (m01_axis_tready) begin
                        m01_axis_tvalid <= 1'b0;
                        state           <= rd_en ? FETCH : EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_buffer.sv
// Directed bench for axis_frame_buffer: store-and-forward instance (DEPTH 8)
// checked against a scoreboard, plus a cut-through instance for latency.
module tb_axis_frame_buffer;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int LIMIT = 400;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic          last;
    } word_t;

    typedef struct {
        logic [DW-1:0] data;
        logic [3:0]    strb;
        logic          last;
        logic [AW:0]   exp_fill;
        logic [AW:0]   exp_frames;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;

    logic [DW-1:0] s_tdata, m_tdata;
    logic [3:0]    s_tstrb, m_tstrb;
    logic          s_tlast, s_tvalid, s_tready;
    logic          m_tlast, m_tvalid, m_tready;
    logic [AW:0]   fill, frames;

    logic [DW-1:0] c_s_tdata, c_m_tdata;
    logic [3:0]    c_s_tstrb, c_m_tstrb;
    logic          c_s_tlast, c_s_tvalid, c_s_tready;
    logic          c_m_tlast, c_m_tvalid, c_m_tready;
    logic [AW:0]   c_fill, c_frames;

    int    checks = 0;
    int    errors = 0;
    word_t sb[$];
    vec_t  vecs[4];

    always #5 clk = ~clk;

    axis_frame_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STORE_FWD(1)) dut_sf (
        .axis_aclk       (clk),
        .axis_aresetn    (rst_n),
        .s01_axis_tdata  (s_tdata),
        .s01_axis_tstrb  (s_tstrb),
        .s01_axis_tlast  (s_tlast),
        .s01_axis_tvalid (s_tvalid),
        .s01_axis_tready (s_tready),
        .m01_axis_tdata  (m_tdata),
        .m01_axis_tstrb  (m_tstrb),
        .m01_axis_tlast  (m_tlast),
        .m01_axis_tvalid (m_tvalid),
        .m01_axis_tready (m_tready),
        .fill_level      (fill),
        .frame_count     (frames)
    );

    axis_frame_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STORE_FWD(0)) dut_ct (
        .axis_aclk       (clk),
        .axis_aresetn    (rst_n),
        .s01_axis_tdata  (c_s_tdata),
        .s01_axis_tstrb  (c_s_tstrb),
        .s01_axis_tlast  (c_s_tlast),
        .s01_axis_tvalid (c_s_tvalid),
        .s01_axis_tready (c_s_tready),
        .m01_axis_tdata  (c_m_tdata),
        .m01_axis_tstrb  (c_m_tstrb),
        .m01_axis_tlast  (c_m_tlast),
        .m01_axis_tvalid (c_m_tvalid),
        .m01_axis_tready (c_m_tready),
        .fill_level      (c_fill),
        .frame_count     (c_frames)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_word(input logic [DW-1:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        s_tdata  = d;
        s_tstrb  = s;
        s_tlast  = l;
        s_tvalid = 1'b1;
        @(negedge clk);
        while (!s_tready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) check("send_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || m_tvalid) && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 64'(n < LIMIT), 64'(1));
    endtask

    // Scoreboard: record accepted input words, compare every output handshake.
    always @(negedge clk) begin
        word_t w;
        if (rst_n) begin
            if (s_tvalid && s_tready) begin
                w = {s_tdata, s_tstrb, s_tlast};
                sb.push_back(w);
            end
            if (m_tvalid && m_tready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 64'(m_tdata), 64'hDEAD);
                end else begin
                    w = sb.pop_front();
                    check("out_data", 64'(m_tdata), 64'(w.data));
                    check("out_strb", 64'(m_tstrb), 64'(w.strb));
                    check("out_last", 64'(m_tlast), 64'(w.last));
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        s_tdata    = '0; s_tstrb = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        m_tready   = 1'b0;
        c_s_tdata  = '0; c_s_tstrb = '0; c_s_tlast = 1'b0; c_s_tvalid = 1'b0;
        c_m_tready = 1'b1;

        vecs[0] = '{32'h0000_00A1, 4'hF, 1'b0, 4'd1, 4'd0};
        vecs[1] = '{32'h0000_00A2, 4'h0, 1'b1, 4'd1, 4'd1};
        vecs[2] = '{32'h0000_00A3, 4'h3, 1'b1, 4'd2, 4'd2};
        vecs[3] = '{32'h0000_00A4, 4'hC, 1'b0, 4'd3, 4'd2};

        // Reset values
        #1;
        check("tready_in_reset", 64'(s_tready), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("tready_before_edge", 64'(s_tready), 64'(0));
        check("rst_tvalid", 64'(m_tvalid), 64'(0));
        check("rst_tdata", 64'(m_tdata), 64'(0));
        check("rst_tstrb", 64'(m_tstrb), 64'(0));
        check("rst_tlast", 64'(m_tlast), 64'(0));
        check("rst_fill", 64'(fill), 64'(0));
        check("rst_frames", 64'(frames), 64'(0));
        @(posedge clk);
        #1;
        check("tready_after_reset", 64'(s_tready), 64'(1));

        // Single-word frame: tvalid by the second edge after acceptance
        m_tready = 1'b1;
        send_word(32'hA5A5_0001, 4'hF, 1'b1);
        check("single_n0_valid", 64'(m_tvalid), 64'(0));
        @(posedge clk); #1;
        check("single_n1_valid", 64'(m_tvalid), 64'(0));
        @(posedge clk); #1;
        check("single_n2_valid", 64'(m_tvalid), 64'(1));
        check("single_data", 64'(m_tdata), 64'hA5A5_0001);
        check("single_strb", 64'(m_tstrb), 64'hF);
        check("single_last", 64'(m_tlast), 64'(1));
        wait_drain("single_drain");
        check("single_fill", 64'(fill), 64'(0));
        check("single_frames", 64'(frames), 64'(0));

        // Table: status after each write with the consumer stalled
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_word(vecs[i].data, vecs[i].strb, vecs[i].last);
            idle(4);
            check($sformatf("tbl_fill_%0d", i), 64'(fill), 64'(vecs[i].exp_fill));
            check($sformatf("tbl_frames_%0d", i), 64'(frames), 64'(vecs[i].exp_frames));
        end
        check("tbl_head_valid", 64'(m_tvalid), 64'(1));
        check("tbl_head_data", 64'(m_tdata), 64'h0000_00A1);
        m_tready = 1'b1;
        idle(10);
        check("tbl_partial_fill", 64'(fill), 64'(1));
        check("tbl_partial_frames", 64'(frames), 64'(0));
        check("tbl_partial_valid", 64'(m_tvalid), 64'(0));
        send_word(32'h0000_00A5, 4'hF, 1'b1);
        wait_drain("tbl_drain");
        check("tbl_fill_end", 64'(fill), 64'(0));

        // 8-word frame, consumer stalled 20 cycles
        m_tready = 1'b0;
        for (int i = 0; i < 8; i++) send_word(32'hB000_0000 + 32'(i), 4'hF, i == 7);
        idle(3);
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", 64'(m_tvalid), 64'(1));
            check("stall_data", 64'(m_tdata), 64'hB000_0000);
            check("stall_last", 64'(m_tlast), 64'(0));
            idle(1);
        end
        m_tready = 1'b1;
        wait_drain("stall_drain");
        check("stall_frames", 64'(frames), 64'(0));

        // Full buffer with no tlast: escape release
        m_tready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_word(32'hC000_0000 + 32'(i), 4'h5, 1'b0);
        s_tdata = 32'hC000_0008; s_tstrb = 4'h5; s_tlast = 1'b0; s_tvalid = 1'b1;
        check("full_tready", 64'(s_tready), 64'(0));
        check("full_fill", 64'(fill), 64'(DEPTH));
        send_word(32'hC000_0008, 4'h5, 1'b0);
        idle(3);
        check("escape_valid", 64'(m_tvalid), 64'(1));
        check("escape_data", 64'(m_tdata), 64'hC000_0000);
        m_tready = 1'b1;
        send_word(32'hC000_0009, 4'h5, 1'b1);
        wait_drain("escape_drain");
        check("escape_fill", 64'(fill), 64'(0));
        check("escape_frames", 64'(frames), 64'(0));

        // Simultaneous write and read issue at fill level 5
        m_tready = 1'b0;
        for (int i = 0; i < 6; i++) send_word(32'hD000_0000 + 32'(i), 4'hF, i == 5);
        idle(4);
        check("sim_pre_fill", 64'(fill), 64'(5));
        check("sim_pre_frames", 64'(frames), 64'(1));
        s_tdata = 32'hD000_0006; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
        m_tready = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        check("sim_fill", 64'(fill), 64'(5));
        send_word(32'hD000_0007, 4'hF, 1'b1);
        wait_drain("sim_drain");

        // Pointer wrap over 3*DEPTH words
        for (int i = 0; i < 3 * DEPTH; i++) send_word(32'hE000_0000 + 32'(i), 4'(i), i % 4 == 3);
        wait_drain("wrap_drain");
        check("wrap_fill", 64'(fill), 64'(0));
        check("wrap_frames", 64'(frames), 64'(0));

        // Cut-through instance: output starts before the frame ends
        c_s_tvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_s_tdata = 32'hF100_0000 + 32'(i);
            c_s_tstrb = 4'hF;
            check("ct_tready", 64'(c_s_tready), 64'(1));
            @(posedge clk); #1;
            if (i == 1) check("ct_n1_valid", 64'(c_m_tvalid), 64'(0));
        end
        c_s_tvalid = 1'b0;
        check("ct_n2_valid", 64'(c_m_tvalid), 64'(1));
        check("ct_n2_data", 64'(c_m_tdata), 64'hF100_0000);
        check("ct_frames", 64'(c_frames), 64'(0));
        idle(2);
        check("ct_w1_data", 64'(c_m_tdata), 64'hF100_0001);
        idle(2);
        check("ct_w2_data", 64'(c_m_tdata), 64'hF100_0002);
        check("ct_w2_last", 64'(c_m_tlast), 64'(0));
        idle(2);
        check("ct_end_valid", 64'(c_m_tvalid), 64'(0));
        check("ct_end_fill", 64'(c_fill), 64'(0));

        // Reset mid-frame with tvalid high on both sides
        m_tready = 1'b0;
        send_word(32'h0000_0F00, 4'hF, 1'b0);
        send_word(32'h0000_0F01, 4'hF, 1'b1);
        send_word(32'h0000_0F02, 4'hF, 1'b0);
        idle(3);
        s_tdata = 32'h0000_0F03; s_tstrb = 4'hF; s_tlast = 1'b0; s_tvalid = 1'b1;
        check("pre_rst_valid", 64'(m_tvalid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_tvalid", 64'(m_tvalid), 64'(0));
        check("arst_tdata", 64'(m_tdata), 64'(0));
        check("arst_tstrb", 64'(m_tstrb), 64'(0));
        check("arst_tlast", 64'(m_tlast), 64'(0));
        check("arst_fill", 64'(fill), 64'(0));
        check("arst_frames", 64'(frames), 64'(0));
        check("arst_tready", 64'(s_tready), 64'(0));
        sb.delete();
        s_tvalid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_tready", 64'(s_tready), 64'(1));
        m_tready = 1'b1;
        send_word(32'h0000_0A00, 4'h3, 1'b0);
        send_word(32'h0000_0A01, 4'h1, 1'b1);
        wait_drain("post_rst_drain");
        check("post_rst_fill", 64'(fill), 64'(0));
        check("post_rst_frames", 64'(frames), 64'(0));

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_buffer.md
# axis_frame_buffer

Single-clock AXI4-Stream frame buffer that sits between a producer and consumer stream in the memory datapath. Words, byte strobes and frame boundaries are written into an on-chip RAM in order and replayed in order, with full AXIS handshaking on both sides. It is parametrised in width and depth and selects cut-through or store-and-forward release at elaboration. Occupancy and frame-count status are exported for the system controller.

## Interface
- DATA_WIDTH, 32: stream data width in bits; multiple of 8.
- ADDR_WIDTH, 10: RAM address width.
- DEPTH = 2**ADDR_WIDTH is a derived value, not a parameter.
- STORE_FWD, 1: 1 = release a frame only when its tlast word is stored; 0 = cut-through.
- axis_aclk  in  1  single clock for the whole block.
- axis_aresetn  in  1  reset, asynchronous assert, active-low.
- s01_axis_tdata  in  DATA_WIDTH  write data.
- s01_axis_tstrb  in  DATA_WIDTH/8  byte strobes, stored with the data.
- s01_axis_tlast  in  1  end of frame.
- s01_axis_tvalid  in  1  write word valid.
- s01_axis_tready  out  1  buffer can accept a word.
- m01_axis_tdata  out  DATA_WIDTH  read data.
- m01_axis_tstrb  out  DATA_WIDTH/8  stored strobes.
- m01_axis_tlast  out  1  stored end of frame.
- m01_axis_tvalid  out  1  read word valid.
- m01_axis_tready  in  1  consumer accepts.
- fill_level  out  ADDR_WIDTH+1  words stored in RAM, not counting the output register.
- frame_count  out  ADDR_WIDTH+1  complete frames stored in RAM.

## Operation
- A write happens when s01_axis_tvalid && s01_axis_tready. The RAM word is {tlast, tstrb, tdata}. wr_ptr increments and wraps modulo DEPTH.
- s01_axis_tready = (fill_level != DEPTH). It is combinational from registered state and does not depend on tvalid.
- frame_count increments on a write with tlast = 1. It decrements when a RAM word with tlast = 1 is fetched into the output register.
- Eligibility to fetch:
  - STORE_FWD=0: fill_level != 0.
  - STORE_FWD=1: frame_count != 0, or fill_level == DEPTH. The second condition is an oversize-frame escape that avoids deadlock; that frame then streams cut-through.
- Read-side FSM:
  - EMPTY: the output register is invalid. When eligible, issue a RAM read and go to FETCH.
  - FETCH: load the output register from RAM, assert m01_axis_tvalid, and go to HOLD.
  - HOLD: on m01_axis_tready, if eligible, issue the next read and go to FETCH; otherwise drop tvalid and go to EMPTY. Without tready, stay in HOLD with outputs stable.
- rd_ptr increments (with wrap) and fill_level decrements in the cycle a RAM read is issued.
- A write and a read issue in the same cycle leave fill_level unchanged. The same applies to frame_count when both the written and the fetched word carry tlast.
- Words with tstrb = 0 are stored and replayed unchanged. The block never interprets strobes.

## Timing
- Reset values: s01_axis_tready 0 while reset is asserted, then 1 on the first clock after deassertion. m01_axis_tvalid 0, m01_axis_tdata 0, m01_axis_tstrb 0, m01_axis_tlast 0, fill_level 0, frame_count 0. Pointers 0, FSM in EMPTY.
- Reset mid-frame discards all stored data and any partial frame. No output glitch is allowed beyond tvalid falling asynchronously.
- Latency, empty buffer: a word accepted in cycle N appears with m01_axis_tvalid in cycle N+2 when STORE_FWD=0. When STORE_FWD=1, it is cycle T+2, where T is the cycle the frame's tlast word is accepted.
- Throughput: sustained 1 word every 2 cycles through the FETCH/HOLD loop.
- AXIS rules: once m01_axis_tvalid is high, tdata, tstrb and tlast hold until the handshake completes. tvalid never drops without a handshake.
- Full: the word arriving while fill_level == DEPTH is not accepted. The producer must hold it.

## Structure
- Shared package memory_pkg holds:
  - the read FSM state typedef (EMPTY, FETCH, HOLD);
  - a helper function for the RAM word width, DATA_WIDTH + DATA_WIDTH/8 + 1.
- Sub-module axis_fb_ram: simple dual-port RAM with one write port and one registered read port, DEPTH x word width, no reset on the array.
- Pointer, counter and FSM logic stay in the top level.

## Test plan
- Single-word frame 0xA5A5_0001, tstrb 0xF, tlast 1, STORE_FWD=1 → output at cycle +2 with identical data, strobes and tlast; afterwards fill_level 0 and frame_count 0.
- 8-word frame with m01_axis_tready held low for 20 cycles → the first word stays stable the whole time. On release, all 8 words arrive in order with tlast on word 8 only.
- Fill with DEPTH words and no tlast, STORE_FWD=1, then offer word DEPTH+1 → s01_axis_tready 0 and fill_level DEPTH. The escape release starts output and tready returns.
- STORE_FWD=0, 3 words without tlast → output starts at cycle +2 before the frame completes; frame_count stays 0.
- Simultaneous write and read issue at fill_level 5 → fill_level stays 5. Pointers wrap correctly across DEPTH-1 → 0 over 3·DEPTH words.
- Assert axis_aresetn low mid-frame with tvalid high on both sides → all outputs reach their reset values immediately. A post-reset frame replays cleanly with no stale words.
